// File: rtl/cdp1861_pkg.sv
// Shared timing constants, CPU state-code encodings and line-classification
// helpers for the CDP1861 video controller.
package cdp1861_pkg;

    localparam int CYCLES_PER_LINE = 14;
    localparam int BYTES_PER_LINE  = 8;
    localparam int DMA_START_CYCLE = 2;

    localparam int FIRST_VIS_LINE  = 80;
    localparam int LAST_VIS_LINE   = 207;
    localparam int INT_LINE        = 78;

    localparam int EF_TOP_FIRST    = 76;
    localparam int EF_TOP_LAST     = 79;
    localparam int EF_BOT_FIRST    = 204;
    localparam int EF_BOT_LAST     = 207;

    localparam int HSYNC_START     = 12;
    localparam int VSYNC_LINES     = 16;

    typedef enum logic [1:0] {
        SC_FETCH = 2'b00,
        SC_EXEC  = 2'b01,
        SC_DMA   = 2'b10,
        SC_INT   = 2'b11
    } sc_e;

    function automatic logic is_visible(input int line);
        return (line >= FIRST_VIS_LINE) && (line <= LAST_VIS_LINE);
    endfunction

    function automatic logic is_ef_line(input int line);
        return ((line >= EF_TOP_FIRST) && (line <= EF_TOP_LAST)) ||
               ((line >= EF_BOT_FIRST) && (line <= EF_BOT_LAST));
    endfunction

endpackage

// File: rtl/cdp1861_shifter.sv
// Pixel serializer: parallel load of a DMA byte, then shift left once per
// clock with zero fill; the MSB is the video output.
module cdp1861_shifter
    import cdp1861_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       msb_o
);
    logic [7:0] sr_q;
    logic [7:0] sr_d;

    always_comb begin
        // NOTE: default assigned first so every path drives sr_d and no latch is inferred.
        sr_d = {sr_q[6:0], 1'b0};
        if (clr_i) begin
            sr_d = '0;
        end else if (load_i) begin
            sr_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb_o = sr_q[7];

endmodule

// File: rtl/cdp1861.sv
// CDP1861-style video controller: line/frame counters, display enable,
// DMA-out request pacing, frame interrupt, EF flag and sync generation.
module cdp1861
    import cdp1861_pkg::*;
#(
    parameter int LINES_PER_FRAME = 262
) (
    input  logic       CLOCK,
    input  logic       CLEAR_N,
    input  logic       cycle_en,
    input  logic [1:0] SC,
    input  logic       disp_on,
    input  logic       disp_off,
    input  logic [7:0] dma_data,
    output logic       dma_out_req,
    output logic       int_req,
    output logic       efx,
    output logic       pixel,
    output logic       hsync,
    output logic       vsync
);
    localparam int              VW            = $clog2(LINES_PER_FRAME);
    localparam logic [3:0]      LAST_CYCLE    = 4'(CYCLES_PER_LINE - 1);
    localparam logic [3:0]      DMA_ARM_CYCLE = 4'(DMA_START_CYCLE - 1);
    localparam logic [3:0]      LAST_BYTE     = 4'(BYTES_PER_LINE - 1);
    localparam logic [3:0]      HSYNC_CYCLE   = 4'(HSYNC_START);
    localparam logic [VW-1:0]   LAST_LINE     = VW'(LINES_PER_FRAME - 1);

    logic [3:0]    hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [3:0]    byte_cnt_q, byte_cnt_d;
    logic          disp_pend_q, disp_pend_d;
    logic          disp_act_q, disp_act_d;
    logic          dma_req_q, dma_req_d;
    logic          int_req_q, int_req_d;
    logic          efx_q, efx_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;

    logic          line_wrap;
    logic          byte_take;
    logic          shift_clr;

    always_comb begin
        line_wrap   = cycle_en && (hcnt_q == LAST_CYCLE);
        byte_take   = cycle_en && dma_req_q && (SC == SC_DMA);
        shift_clr   = !(disp_act_q && is_visible(int'(vcnt_q)));

        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        byte_cnt_d  = byte_cnt_q;
        disp_act_d  = disp_act_q;
        dma_req_d   = dma_req_q;
        int_req_d   = int_req_q;

        // Off beats on when both requests arrive on the same clock.
        disp_pend_d = disp_off ? 1'b0 : (disp_on ? 1'b1 : disp_pend_q);

        if (int_req_q && cycle_en && (SC == SC_INT)) begin
            int_req_d = 1'b0;
        end

        if (cycle_en) begin
            hcnt_d = line_wrap ? 4'd0 : hcnt_q + 4'd1;
        end

        if (line_wrap) begin
            vcnt_d     = (vcnt_q == LAST_LINE) ? '0 : vcnt_q + VW'(1);
            disp_act_d = disp_pend_d;
            byte_cnt_d = '0;
            dma_req_d  = 1'b0;
            if ((int'(vcnt_d) == INT_LINE) && disp_act_d) begin
                int_req_d = 1'b1;
            end
            if (int'(vcnt_d) == FIRST_VIS_LINE) begin
                int_req_d = 1'b0;
            end
        end else begin
            if (cycle_en && (hcnt_q == DMA_ARM_CYCLE) && !shift_clr) begin
                dma_req_d = 1'b1;
            end
            if (byte_take) begin
                byte_cnt_d = byte_cnt_q + 4'd1;
                if (byte_cnt_q == LAST_BYTE) begin
                    dma_req_d = 1'b0;
                end
            end
        end

        // Flags are derived from next-state counters so they line up with hcnt/vcnt.
        efx_d   = is_ef_line(int'(vcnt_d));
        hsync_d = (hcnt_d >= HSYNC_CYCLE);
        vsync_d = (int'(vcnt_d) < VSYNC_LINES);
    end

    always_ff @(posedge CLOCK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            byte_cnt_q  <= '0;
            disp_pend_q <= 1'b0;
            disp_act_q  <= 1'b0;
            dma_req_q   <= 1'b0;
            int_req_q   <= 1'b0;
            efx_q       <= 1'b0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            byte_cnt_q  <= byte_cnt_d;
            disp_pend_q <= disp_pend_d;
            disp_act_q  <= disp_act_d;
            dma_req_q   <= dma_req_d;
            int_req_q   <= int_req_d;
            efx_q       <= efx_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
        end
    end

    cdp1861_shifter u_shifter (
        .clk    (CLOCK),
        .rst_n  (CLEAR_N),
        .clr_i  (shift_clr),
        .load_i (byte_take),
        .data_i (dma_data),
        .msb_o  (pixel)
    );

    assign dma_out_req = dma_req_q;
    assign int_req     = int_req_q;
    assign efx         = efx_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;

endmodule

// File: doc/cdp1861.md
CDP1861 -- requirements
Module: cdp1861

Interface
REQ-001 SHALL have parameter: LINES_PER_FRAME, 262, total scan lines per frame (counter wrap point).
REQ-002 SHALL have ports (clock and reset first):
- CLOCK  in  1  system clock; pixel rate.
- CLEAR_N  in  1  reset; one clock; reset is asynchronous and active-low.
- cycle_en  in  1  one-CLOCK strobe marking each CPU machine cycle.
- SC  in  2  CPU state code (00 fetch, 01 execute, 10 DMA, 11 interrupt).
- disp_on  in  1  one-CLOCK pulse, display enable request (decoded INP 1).
- disp_off  in  1  one-CLOCK pulse, display disable request (decoded OUT 1).
- dma_data  in  8  byte driven by CPU during S2 DMA-out cycle.
- dma_out_req  out  1  DMA-out request to CPU, active-high.
- int_req  out  1  interrupt request to CPU, active-high.
- efx  out  1  frame-position flag to CPU EF1, active-high.
- pixel  out  1  serial video, 1 = lit.
- hsync  out  1  horizontal sync, active-high.
- vsync  out  1  vertical sync, active-high.

Function
REQ-003 SHALL keep hcnt 0..13, advanced only on cycle_en, wrapping 13->0.
REQ-004 SHALL keep vcnt 0..LINES_PER_FRAME-1, incremented when hcnt wraps, wrapping LINES_PER_FRAME-1->0.
REQ-005 SHALL latch disp_on/disp_off into pending state immediately; the active display flag SHALL update only at hcnt wrap (no partial lines). Simultaneous disp_on and disp_off: disp_off wins.
REQ-006 SHALL define visible lines as vcnt 80..207 (128 lines).
REQ-007 SHALL assert dma_out_req on the CLOCK after the cycle_en that makes hcnt=2, on visible lines with display active.
- Byte count: each cycle_en with SC=10 while dma_out_req is high SHALL count one byte.
- dma_out_req SHALL deassert on the CLOCK after the 8th counted byte.
- Byte count SHALL clear at each hcnt wrap.
REQ-008 If the display flag goes inactive, dma_out_req SHALL deassert at that line boundary. If a line ends with fewer than 8 bytes taken, the remainder SHALL be dropped and dma_out_req SHALL drop at the wrap.
REQ-009 On each counted S2 cycle, SHALL load dma_data into an 8-bit shift register. Between loads, SHALL shift left one bit per CLOCK. pixel = register MSB; zeros shift in.
REQ-010 pixel SHALL be 0 outside visible lines or when display is inactive.
REQ-011 SHALL assert int_req from the start of vcnt 78 with display active.
- Clear on the first cycle_en with SC=11 (acknowledge), or at the start of vcnt 80, whichever comes first.
- SHALL not reassert in the same frame after acknowledge.
REQ-012 efx SHALL be 1 for vcnt 76..79 and 204..207 regardless of display state; otherwise 0.
REQ-013 hsync SHALL be 1 when hcnt is 12 or 13. vsync SHALL be 1 when vcnt is 0..15.
REQ-014 All outputs SHALL be registered; no output combinationally from inputs.

Reset
REQ-015 While CLEAR_N=0, SHALL force:
- hcnt=0, vcnt=0, byte count=0, shift register=0.
- display active and pending both off.
- dma_out_req=0, int_req=0, efx=0, pixel=0, hsync=0, vsync=0.
REQ-016 Reset asserted mid-line or mid-DMA SHALL abort immediately. After release, operation SHALL resume from hcnt=0, vcnt=0 with the display off.

Structure
REQ-017 Shared package cdp1861_pkg SHALL hold:
- CYCLES_PER_LINE=14, BYTES_PER_LINE=8, DMA_START_CYCLE=2.
- FIRST_VIS_LINE=80, LAST_VIS_LINE=207, INT_LINE=78.
- EF windows (76..79, 204..207), HSYNC_START=12, VSYNC_LINES=16.
- SC encodings (SC_FETCH, SC_EXEC, SC_DMA, SC_INT).
REQ-018 The serializer SHALL be one sub-module, cdp1861_shifter: load, shift, MSB out. Counters and control SHALL stay in cdp1861.

Verification
REQ-019 Reset release, cycle_en every 8 CLOCKs, no disp_on -> dma_out_req and int_req stay 0 for a full frame; efx high exactly on lines 76..79, 204..207; vsync lines 0..15.
REQ-020 disp_on pulse on line 10; CPU model answers every dma_out_req with SC=10 and bytes 0x80,0x01,0xFF,0x00,0xAA,0x55,0x0F,0xF0 -> on line 80, 8 bytes accepted, dma_out_req drops after the 8th, pixel stream matches bytes MSB-first.
REQ-021 Display on, no acknowledge -> int_req high from line 78 start, cleared at line 80 start. Repeat with SC=11 on line 78 hcnt 5 -> int_req clears next CLOCK, stays 0 through line 79.
REQ-022 disp_off pulse at line 100 hcnt 4 -> line 100 completes 8 DMA bytes; no dma_out_req from line 101; pixel 0. disp_on+disp_off same CLOCK -> display stays off.
REQ-023 CPU grants only 5 S2 cycles on line 90 -> dma_out_req held to hcnt wrap, then drops; line 91 requests a fresh 8.
REQ-024 CLEAR_N pulsed low at line 150 hcnt 6 mid-DMA -> all outputs 0 asynchronously; after release hcnt=vcnt=0, display off, no DMA until new disp_on.
